// File: rtl/mips32_trace_buffer.sv
// mips32_trace_buffer: circular commit-trace capture with trigger, post-trigger window and oldest-first drain.
// Optional macro MIPS32_TRACE_FILTER_EN adds a reg_mask port that filters register-write capture.
//
// state | meaning
// IDLE  | not capturing; arm starts a new capture
// ARMED | capturing into the circular buffer; waiting for trig
// POST  | capturing the post-trigger window of POST_TRIG events
// DRAIN | frozen; entries presented oldest-first on the out_* port
module mips32_trace_buffer #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 32,
    parameter int DEPTH      = 16,
    parameter int POST_TRIG  = 4,
    parameter int CYC_W      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   trig,
    input  logic                   reg_write,
    input  logic [4:0]             reg_addr,
    input  logic [DATA_W-1:0]      reg_data,
    input  logic                   mem_write,
    input  logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
`ifdef MIPS32_TRACE_FILTER_EN
    input  logic [31:0]            reg_mask,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_kind,
    output logic [MEM_ADDR_W-1:0]  out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [CYC_W-1:0]       out_cycle,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   wrapped,
    output logic                   collision
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] POST_LOAD = PTR_W'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [PTR_W-1:0] wptr, rptr, rptr_nxt, post_cnt;
    logic [CYC_W-1:0] cyc;

    logic                  buf_kind  [DEPTH];
    logic [MEM_ADDR_W-1:0] buf_addr  [DEPTH];
    logic [DATA_W-1:0]     buf_data  [DEPTH];
    logic [CYC_W-1:0]      buf_cycle [DEPTH];

    logic                  reg_hit, evt, cap, cap_en;
    logic                  evt_kind;
    logic [MEM_ADDR_W-1:0] evt_addr;
    logic [DATA_W-1:0]     evt_data;
    logic                  arm_ok, trig_ok, xfer, load_first, load_next;

`ifdef MIPS32_TRACE_FILTER_EN
    // $zero writes carry no architectural effect, so they are never logged
    assign reg_hit = reg_write && (reg_addr != 5'd0) && reg_mask[reg_addr];
`else
    assign reg_hit = reg_write;
`endif

    // memory writes win when both strobes fire
    assign evt      = mem_write || reg_hit;
    assign evt_kind = mem_write;
    assign evt_addr = mem_write ? mem_addr : MEM_ADDR_W'(reg_addr);
    assign evt_data = mem_write ? mem_data : reg_data;
    assign cap      = cap_en && evt;
    assign rptr_nxt = rptr + PTR_ONE;
    assign state    = state_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm) state_d = S_ARMED;
            S_ARMED: if (trig) state_d = (POST_TRIG == 0) ? S_DRAIN : S_POST;
            S_POST:  if (evt && post_cnt == PTR_ONE) state_d = S_DRAIN;
            S_DRAIN: if ((!out_valid && count == '0) || (xfer && count == CNT_ONE))
                         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arm_ok     = 1'b0;
        trig_ok    = 1'b0;
        cap_en     = 1'b0;
        xfer       = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state_q)
            S_IDLE:  arm_ok = arm;
            S_ARMED: begin
                cap_en  = 1'b1;
                trig_ok = trig;
            end
            S_POST:  cap_en = 1'b1;
            S_DRAIN: begin
                xfer       = out_valid && out_ready;
                load_first = !out_valid && (count != '0);
                load_next  = out_valid && out_ready && (count > CNT_ONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && cap) begin
            buf_kind[wptr]  <= evt_kind;
            buf_addr[wptr]  <= evt_addr;
            buf_data[wptr]  <= evt_data;
            buf_cycle[wptr] <= cyc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            post_cnt  <= '0;
            cyc       <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            collision <= 1'b0;
            out_valid <= 1'b0;
            out_kind  <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_cycle <= '0;
        end else begin
            cyc <= cyc + CYC_W'(1);
            if (arm_ok) begin
                wptr      <= '0;
                rptr      <= '0;
                count     <= '0;
                wrapped   <= 1'b0;
                collision <= 1'b0;
            end
            if (cap) begin
                wptr <= wptr + PTR_ONE;
                // full: the write lands on the oldest entry, so the read side follows it
                if (count == FULL) begin
                    rptr    <= rptr_nxt;
                    wrapped <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
                if (mem_write && reg_hit) collision <= 1'b1;
            end
            if (trig_ok)
                post_cnt <= POST_LOAD;
            else if (cap && state_q == S_POST)
                post_cnt <= post_cnt - PTR_ONE;
            if (load_first) begin
                out_valid <= 1'b1;
                out_kind  <= buf_kind[rptr];
                out_addr  <= buf_addr[rptr];
                out_data  <= buf_data[rptr];
                out_cycle <= buf_cycle[rptr];
            end
            if (xfer) begin
                rptr  <= rptr_nxt;
                count <= count - CNT_ONE;
                if (load_next) begin
                    out_kind  <= buf_kind[rptr_nxt];
                    out_addr  <= buf_addr[rptr_nxt];
                    out_data  <= buf_data[rptr_nxt];
                    out_cycle <= buf_cycle[rptr_nxt];
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips32_trace_buffer.sv
// Bench for mips32_trace_buffer: queue-based reference model feeding a scoreboard, plus a
// POST_TRIG=0 instance for immediate-drain scenarios. Honours MIPS32_TRACE_FILTER_EN.
module tb_mips32_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PT    = 4;

    typedef struct packed {
        logic        kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cyc;
    } entry_t;

    logic clock;
    logic reset, hold0, rst0;
    logic arm, trig, reg_write, mem_write, out_ready;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data, mem_addr, mem_data;
`ifdef MIPS32_TRACE_FILTER_EN
    logic [31:0] reg_mask;
`endif

    logic        out_valid, out_kind, wrapped, collision;
    logic [31:0] out_addr, out_data;
    logic [15:0] out_cycle;
    logic [4:0]  count;
    logic [1:0]  state;

    logic        out_valid0, out_kind0, wrapped0, collision0;
    logic [31:0] out_addr0, out_data0;
    logic [15:0] out_cycle0;
    logic [4:0]  count0;
    logic [1:0]  state0;

    assign rst0 = reset | hold0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mips32_trace_buffer #(.DATA_W(32), .MEM_ADDR_W(32), .DEPTH(DEPTH), .POST_TRIG(PT), .CYC_W(16)) dut (
        .clock(clock), .reset(reset), .arm(arm), .trig(trig),
        .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef MIPS32_TRACE_FILTER_EN
        .reg_mask(reg_mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_addr(out_addr), .out_data(out_data), .out_cycle(out_cycle),
        .count(count), .state(state), .wrapped(wrapped), .collision(collision)
    );

    mips32_trace_buffer #(.DATA_W(32), .MEM_ADDR_W(32), .DEPTH(DEPTH), .POST_TRIG(0), .CYC_W(16)) dut0 (
        .clock(clock), .reset(rst0), .arm(arm), .trig(trig),
        .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef MIPS32_TRACE_FILTER_EN
        .reg_mask(reg_mask),
`endif
        .out_valid(out_valid0), .out_ready(out_ready), .out_kind(out_kind0),
        .out_addr(out_addr0), .out_data(out_data0), .out_cycle(out_cycle0),
        .count(count0), .state(state0), .wrapped(wrapped0), .collision(collision0)
    );

    int errors = 0;
    int checks = 0;

    // reference model: captured history as a queue, phase as 0..3
    logic [1:0]  m_st;
    entry_t      m_q[$];
    entry_t      exp_q[$];
    int          m_post;
    bit          m_wr, m_coll, m_ov;
    logic [15:0] m_cyc;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic enter_drain();
        foreach (m_q[i]) exp_q.push_back(m_q[i]);
    endtask

    task automatic model_step();
        logic [1:0] st;
        bit hit;
        entry_t e;
        if (reset) begin
            m_st = 2'd0; m_q.delete(); exp_q.delete();
            m_post = 0; m_wr = 0; m_coll = 0; m_ov = 0; m_cyc = '0;
            return;
        end
`ifdef MIPS32_TRACE_FILTER_EN
        hit = reg_write && (reg_addr != 5'd0) && reg_mask[reg_addr];
`else
        hit = reg_write;
`endif
        if (mem_write) e = {1'b1, mem_addr, mem_data, m_cyc};
        else           e = {1'b0, 27'b0, reg_addr, reg_data, m_cyc};
        st = m_st;
        case (st)
            2'd0: if (arm) begin
                m_q.delete(); m_wr = 0; m_coll = 0; m_st = 2'd1;
            end
            2'd1, 2'd2: begin
                if (mem_write || hit) begin
                    if (m_q.size() == DEPTH) begin
                        void'(m_q.pop_front());
                        m_wr = 1;
                    end
                    m_q.push_back(e);
                    if (mem_write && hit) m_coll = 1;
                    if (st == 2'd2) begin
                        m_post--;
                        if (m_post == 0) begin m_st = 2'd3; enter_drain(); end
                    end
                end
                if (st == 2'd1 && trig) begin
                    if (PT == 0) begin m_st = 2'd3; enter_drain(); end
                    else begin m_st = 2'd2; m_post = PT; end
                end
            end
            default: begin
                if (!m_ov) begin
                    if (m_q.size() == 0) m_st = 2'd0;
                    else m_ov = 1;
                end else if (out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin m_ov = 0; m_st = 2'd0; end
                end
            end
        endcase
        m_cyc++;
    endtask

    task automatic check_status();
        check("status", 96'({state, count, out_valid, wrapped, collision}),
              96'({m_st, 5'(m_q.size()), m_ov, m_wr, m_coll}));
    endtask

    // inputs change #1 after posedge; DUT sampled at negedge
    task automatic tick();
        @(negedge clock);
        check_status();
        @(posedge clock);
        model_step();
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL drain_extra: got entry %0h with none expected", {out_kind, out_addr, out_data, out_cycle});
            end else begin
                check("drain_entry", 96'({out_kind, out_addr, out_data, out_cycle}), 96'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle_in();
        arm = 0; trig = 0; reg_write = 0; mem_write = 0;
    endtask

    task automatic do_reset();
        idle_in();
        out_ready = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic rand_events();
        mem_write = ($urandom_range(0, 3) == 0);
        reg_write = ($urandom_range(0, 1) == 1);
        reg_addr  = 5'($urandom);
        reg_data  = $urandom;
        mem_addr  = $urandom;
        mem_data  = $urandom;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n;
        n = 0;
        while (m_st != 2'd0 && n < budget) begin
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rnd) rand_events();
            tick();
            n++;
        end
        idle_in();
        out_ready = 0;
        checks++;
        if (m_st != 2'd0) begin
            errors++;
            $display("FAIL wait_idle: still in state %0d after %0d cycles", m_st, budget);
        end
    endtask

    task automatic mem_burst(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            mem_write = 1; mem_addr = $urandom; mem_data = base + i;
            tick();
        end
        mem_write = 0;
    endtask

    initial begin
        idle_in();
        out_ready = 0; hold0 = 1; reset = 1;
        reg_addr = '0; reg_data = '0; mem_addr = '0; mem_data = '0;
`ifdef MIPS32_TRACE_FILTER_EN
        reg_mask = 32'hFFFF_FFFF;
`endif
        m_st = 0; m_post = 0; m_wr = 0; m_coll = 0; m_ov = 0; m_cyc = '0;
        repeat (2) begin @(posedge clock); model_step(); end
        #1;

        // reset state and immediate-drain instance: three reg writes stamped 5,6,7
        hold0 = 0;
        do_reset();
        check("reset_status", 96'({state, count, out_valid, wrapped, collision}), 96'(0));
        check("reset_out", 96'({out_kind, out_addr, out_data, out_cycle}), 96'(0));
        arm = 1; tick(); arm = 0;
        for (int k = 0; k < 10 && m_cyc != 16'd5; k++) tick();
        for (int i = 1; i <= 3; i++) begin
            reg_write = 1; reg_addr = 5'(i); reg_data = 32'h9 + 32'(i);
            tick();
        end
        reg_write = 0; trig = 1; tick(); trig = 0;
        check("t1_enter_drain", 96'({state0, count0, out_valid0}), 96'({2'd3, 5'd3, 1'b0}));
        out_ready = 1; tick();
        for (int i = 0; i < 3; i++) begin
            check("t1_entry", 96'({out_valid0, out_kind0, out_addr0, out_data0, out_cycle0}),
                  96'({1'b1, 1'b0, 32'(i + 1), 32'hA + 32'(i), 16'(5 + i)}));
            tick();
        end
        check("t1_done", 96'({state0, count0, out_valid0, wrapped0}), 96'(0));
        out_ready = 0;

        // overflow on the immediate-drain instance: 20 writes keep 4..19
        do_reset();
        arm = 1; tick(); arm = 0;
        mem_burst(20, 0);
        trig = 1; tick(); trig = 0;
        check("t2_full", 96'({state0, count0, wrapped0}), 96'({2'd3, 5'd16, 1'b1}));
        out_ready = 1; tick();
        for (int i = 0; i < 16; i++) begin
            check("t2_order", 96'({out_valid0, out_data0}), 96'({1'b1, 32'(4 + i)}));
            mem_write = (i < 4); mem_addr = $urandom; mem_data = 100 + i;
            tick();
        end
        mem_write = 0;
        check("t2_idle", 96'({state0, out_valid0}), 96'(0));
        hold0 = 1;
        wait_idle(64, 0);

        // post-trigger window of 4 reg writes, 5th ignored in DRAIN
        do_reset();
        arm = 1; tick(); arm = 0;
        trig = 1; tick(); trig = 0;
        for (int i = 0; i < 4; i++) begin
            check("t3_post", 96'(state), 96'(2'd2));
            reg_write = 1; reg_addr = 5'(i + 1); reg_data = $urandom;
            tick();
        end
        reg_write = 0;
        check("t3_drain", 96'({state, count}), 96'({2'd3, 5'd4}));
        reg_write = 1; reg_addr = 5'd9; tick(); reg_write = 0;
        check("t3_no_capture", 96'(count), 96'(5'd4));
        wait_idle(64, 0);

        // collision: mem wins, one entry
        do_reset();
        arm = 1; tick(); arm = 0;
        reg_write = 1; reg_addr = 5'd5; reg_data = 32'h1;
        mem_write = 1; mem_addr = 32'h10; mem_data = 32'h2;
        tick();
        idle_in();
        check("t4_collision", 96'({collision, count}), 96'({1'b1, 5'd1}));
        trig = 1; tick(); trig = 0;
        mem_burst(4, 50);
        tick();
        check("t4_first", 96'({out_valid, out_kind, out_addr, out_data}), 96'({1'b1, 1'b1, 32'h10, 32'h2}));
        wait_idle(64, 0);

        // back-pressure then reset mid-drain
        do_reset();
        arm = 1; tick(); arm = 0;
        mem_burst(6, 0);
        trig = 1; tick(); trig = 0;
        mem_burst(4, 6);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5_hold", 96'({out_valid, count, out_data}), 96'({1'b1, 5'd10, 32'd0}));
            tick();
        end
        out_ready = 1; tick(); out_ready = 0;
        reset = 1; tick(); reset = 0;
        check("t5_reset", 96'({state, count, out_valid}), 96'(0));

        // register filter: writes to $0,$1,$2 with only bit 2 enabled
        do_reset();
`ifdef MIPS32_TRACE_FILTER_EN
        reg_mask = 32'h0000_0004;
`endif
        arm = 1; tick(); arm = 0;
        for (int i = 0; i < 3; i++) begin
            reg_write = 1; reg_addr = 5'(i); reg_data = 32'h100 + 32'(i);
            tick();
        end
        reg_write = 0;
`ifdef MIPS32_TRACE_FILTER_EN
        check("t6_filtered", 96'(count), 96'(5'd1));
`else
        check("t6_unfiltered", 96'(count), 96'(5'd3));
`endif
        trig = 1; tick(); trig = 0;
        mem_burst(4, 200);
        wait_idle(64, 0);

        // randomized capture rounds, some re-armed without reset
        for (int r = 0; r < 8; r++) begin
            int n;
            if (r % 3 == 0) do_reset();
`ifdef MIPS32_TRACE_FILTER_EN
            reg_mask = $urandom;
`endif
            arm = 1; tick(); arm = 0;
            n = $urandom_range(2, 40);
            for (int i = 0; i < n; i++) begin
                rand_events();
                arm = $urandom_range(0, 1);
                tick();
            end
            arm = 0;
            rand_events(); trig = 1; tick(); trig = 0;
            for (int k = 0; k < 300 && m_st == 2'd2; k++) begin
                rand_events();
                trig = $urandom_range(0, 1);
                tick();
            end
            idle_in();
            wait_idle(300, 1);
        end

        tick();
        check("scoreboard_empty", 96'(exp_q.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
